mpadder_arbiter: RTL and testbench

//   Shares one mpadder instance between two requesters (port 0, port 1), e.g. Montgomery loop + final reduction.

---
 rtl/mpadder_arbiter_if.sv | 47 ++++
 rtl/mpadder_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mpadder_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpadder_arbiter_if.sv
// Bundle of both requester channels and the mpadder-side signals of mpadder_arbiter.
// slave = arbiter side; master = environment (requesters plus the shared mpadder).
interface mpadder_arbiter_if #(
  parameter int unsigned WIDTH = 1027
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_sub;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             resp0_valid;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_sub;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             resp1_valid;

  logic [WIDTH:0]   resp_result;
  logic             resp_err;

  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_in_a;
  logic [WIDTH-1:0] add_in_b;
  logic [WIDTH:0]   add_result;
  logic             add_done;

  modport slave (
    input  req0_valid, req0_sub, req0_a, req0_b,
    input  req1_valid, req1_sub, req1_a, req1_b,
    input  add_result, add_done,
    output req0_ready, resp0_valid, req1_ready, resp1_valid,
    output resp_result, resp_err,
    output add_start, add_subtract, add_in_a, add_in_b
  );

  modport master (
    output req0_valid, req0_sub, req0_a, req0_b,
    output req1_valid, req1_sub, req1_a, req1_b,
    output add_result, add_done,
    input  req0_ready, resp0_valid, req1_ready, resp1_valid,
    input  resp_result, resp_err,
    input  add_start, add_subtract, add_in_a, add_in_b
  );
endinterface

// File: rtl/mpadder_arbiter.sv
// Round-robin sharing of one mpadder between two add/subtract requesters.
// Define MPADD_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (resp_err on expiry).
module mpadder_arbiter #(
  parameter int unsigned WIDTH          = 1027,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              resetn,
  mpadder_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
    $error("mpadder_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           stateNext;

  logic             lastGrant;
  logic             owner;
  logic             capSub;
  logic [WIDTH-1:0] capA;
  logic [WIDTH-1:0] capB;
  logic [WIDTH:0]   resultReg;

  logic             grantValid;
  logic             grantPort;
  logic             accept;
  logic             timeoutHit;

`ifdef MPADD_ARB_TIMEOUT_EN
  logic [15:0]      timer;
  logic             errReg;

  // timer counts completed WAIT cycles; expiry is seen on the cycle that would reach the limit
  assign timeoutHit = (state == WAIT) && ((timer + 16'd1) == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (state == START) begin
      timer <= '0;
    end else if (state == WAIT) begin
      timer <= timer + 16'd1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Tie goes to the port that was not served last.
  always_comb begin
    grantValid = 1'b0;
    grantPort  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grantValid = 1'b1;
      grantPort  = ~lastGrant;
    end else if (bus.req0_valid) begin
      grantValid = 1'b1;
      grantPort  = 1'b0;
    end else if (bus.req1_valid) begin
      grantValid = 1'b1;
      grantPort  = 1'b1;
    end
  end

  assign accept = (state == IDLE) && grantValid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext       = state;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    bus.add_start   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req0_ready = grantValid && !grantPort;
        bus.req1_ready = grantValid && grantPort;
        if (accept) begin
          stateNext = START;
        end
      end
      START: begin
        bus.add_start = 1'b1;
        stateNext     = WAIT;
      end
      WAIT: begin
        if (bus.add_done || timeoutHit) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        bus.resp0_valid = !owner;
        bus.resp1_valid = owner;
        stateNext       = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lastGrant <= 1'b1;
      owner     <= 1'b0;
      capSub    <= 1'b0;
      capA      <= '0;
      capB      <= '0;
      resultReg <= '0;
    end else begin
      if (accept) begin
        lastGrant <= grantPort;
        owner     <= grantPort;
        capSub    <= grantPort ? bus.req1_sub : bus.req0_sub;
        capA      <= grantPort ? bus.req1_a   : bus.req0_a;
        capB      <= grantPort ? bus.req1_b   : bus.req0_b;
      end
      if (state == WAIT) begin
        if (bus.add_done) begin
          resultReg <= bus.add_result;
        end else if (timeoutHit) begin
          resultReg <= '0;
        end
      end
    end
  end

`ifdef MPADD_ARB_TIMEOUT_EN
  // add_done wins over expiry when both land on the same WAIT cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      errReg <= 1'b0;
    end else if (state == WAIT) begin
      if (bus.add_done) begin
        errReg <= 1'b0;
      end else if (timeoutHit) begin
        errReg <= 1'b1;
      end
    end
  end

  assign bus.resp_err = (state == RESP) && errReg;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.resp_result  = resultReg;
  assign bus.add_subtract = capSub;
  assign bus.add_in_a     = capA;
  assign bus.add_in_b     = capB;

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Self-checking bench for mpadder_arbiter with a behavioural mpadder stub and a response scoreboard.
module tb_mpadder_arbiter;
  localparam int unsigned W  = 1027;
  localparam int unsigned TO = 64;

  typedef struct {
    bit           port;
    logic [W:0]   result;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   cycle = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   lastGrantTb = 1'b1;
  exp_t sbQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  mpadder_arbiter_if #(.WIDTH(W)) bus ();

  mpadder_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // mpadder stub: samples add_start, raises done stubDelay edges later using the live operands
  int         stubDelay = 1;
  bit         stubEnable = 1'b1;
  int         pendCnt;
  logic       stubDone;
  logic [W:0] stubResult;
  logic       forceDone = 1'b0;
  logic [W:0] forceResult = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pendCnt    <= 0;
      stubDone   <= 1'b0;
      stubResult <= '0;
    end else begin
      stubDone <= 1'b0;
      if (bus.add_start) begin
        pendCnt <= stubDelay;
      end else if (pendCnt > 0) begin
        pendCnt <= pendCnt - 1;
        if (pendCnt == 1 && stubEnable) begin
          stubDone   <= 1'b1;
          stubResult <= bus.add_subtract ? ({1'b0, bus.add_in_a} - {1'b0, bus.add_in_b})
                                         : ({1'b0, bus.add_in_a} + {1'b0, bus.add_in_b});
        end
      end
    end
  end

  assign bus.add_done   = stubDone | forceDone;
  assign bus.add_result = forceDone ? forceResult : stubResult;

  // Scoreboard monitor
  exp_t monExp;
  always @(negedge clk) begin
    if (resetn === 1'b1 && (bus.resp0_valid === 1'b1 || bus.resp1_valid === 1'b1)) begin
      testsRun++;
      if (bus.resp0_valid === 1'b1 && bus.resp1_valid === 1'b1) begin
        testsFailed++;
        $display("FAIL resp_both: resp0_valid=1 resp1_valid=1, required one-hot");
      end else if (sbQ.size() == 0) begin
        testsFailed++;
        $display("FAIL spurious_resp: port=%0d at cycle %0d, required no response", bus.resp1_valid, cycle);
      end else begin
        monExp = sbQ.pop_front();
        if (bus.resp1_valid !== monExp.port || bus.resp_result !== monExp.result ||
            bus.resp_err !== monExp.err) begin
          testsFailed++;
          $display("FAIL sb_resp: got port=%0d err=%0b msb=%0b low=%h, required port=%0d err=%0b msb=%0b low=%h",
                   bus.resp1_valid, bus.resp_err, bus.resp_result[W], bus.resp_result[63:0],
                   monExp.port, monExp.err, monExp.result[W], monExp.result[63:0]);
        end
      end
    end
  end

  function automatic logic [W-1:0] randOp();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 33; i++) r = (r << 32) | {{(W-32){1'b0}}, $urandom()};
    return r;
  endfunction

  task automatic drivePort(input bit port, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sub);
    if (port) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end
  endtask

  task automatic issueJob(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W:0] expRes, input logic expErr,
                          output int accCyc);
    bit seen = 1'b0;
    accCyc = cycle;
    @(negedge clk);
    drivePort(port, 1'b1, a, b, sub);
    for (int g = 0; g < 100 && !seen; g++) begin
      #1;
      if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        seen   = 1'b1;
        accCyc = cycle;
        sbQ.push_back(exp_t'{port: port, result: expRes, err: expErr});
        lastGrantTb = port;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      testsRun++; testsFailed++;
      $display("FAIL accept_timeout: port %0d never ready, required acceptance", port);
    end
  endtask

  task automatic waitResp(input bit port, input int accCyc, input int expLat, input string name);
    bit seen = 1'b0;
    int lat = -1;
    for (int g = 0; g < expLat + 50 && !seen; g++) begin
      @(negedge clk);
      if ((port ? bus.resp1_valid : bus.resp0_valid) === 1'b1) begin
        seen = 1'b1;
        lat  = cycle - accCyc;
      end
    end
    testsRun++;
    if (lat != expLat) begin
      testsFailed++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, expLat);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_err,
         bus.add_start, bus.add_subtract} !== 7'b0 || bus.resp_result !== '0 ||
        bus.add_in_a !== '0 || bus.add_in_b !== '0) begin
      testsFailed++;
      $display("FAIL reset_outputs: start=%b sub=%b r0=%b r1=%b, required all 0",
               bus.add_start, bus.add_subtract, bus.resp0_valid, bus.resp1_valid);
    end
    resetn = 1'b1;
    lastGrantTb = 1'b1;
    @(negedge clk);
    drivePort(0, 1'b1, '0, '0, 1'b0);
    drivePort(1, 1'b1, '0, '0, 1'b0);
    #1;
    testsRun++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_first_tie: ready0=%b ready1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
    end
    drivePort(0, 1'b0, '0, '0, 1'b0);
    drivePort(1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_port0_add();
    int  acc;
    int  lat = -1;
    bit  busyReady = 1'b0;
    issueJob(0, W'(5), W'(3), 1'b0, (W+1)'(8), 1'b0, acc);
    drivePort(0, 1'b1, W'(99), W'(77), 1'b1);
    for (int g = 0; g < 20 && lat < 0; g++) begin
      @(negedge clk);
      if (bus.req0_ready !== 1'b0) busyReady = 1'b1;
      if (bus.resp0_valid === 1'b1) lat = cycle - acc;
    end
    drivePort(0, 1'b0, '0, '0, 1'b0);
    testsRun++;
    if (busyReady) begin
      testsFailed++;
      $display("FAIL busy_ready: ready0 went 1 while busy, required 0");
    end
    testsRun++;
    if (lat != 4) begin
      testsFailed++;
      $display("FAIL add0_latency: got %0d cycles, required 4", lat);
    end
  endtask

  task automatic test_port1_sub();
    int acc;
    logic [W:0] e = '1;
    e[0] = 1'b0;
    issueJob(1, W'(3), W'(5), 1'b1, e, 1'b0, acc);
    drivePort(1, 1'b0, '0, '0, 1'b0);
    waitResp(1, acc, 4, "sub1");
  endtask

  task automatic test_round_robin();
    logic [W-1:0] a[2];
    logic [W-1:0] b[2];
    logic         s[2];
    int  jobs[2] = '{0, 0};
    bit  expPort = !lastGrantTb;
    bit  port;
    int  prevAcc = -1;
    for (int p = 0; p < 2; p++) begin
      a[p] = randOp(); b[p] = randOp(); s[p] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    drivePort(0, 1'b1, a[0], b[0], s[0]);
    drivePort(1, 1'b1, a[1], b[1], s[1]);
    for (int g = 0; g < 200 && (jobs[0] + jobs[1]) < 8; g++) begin
      #1;
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        port = bus.req1_ready;
        testsRun++;
        if (port !== expPort || (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1)) begin
          testsFailed++;
          $display("FAIL rr_order: granted port %0d (ready0=%b ready1=%b), required %0d",
                   port, bus.req0_ready, bus.req1_ready, expPort);
        end
        if (prevAcc >= 0) begin
          testsRun++;
          if (cycle - prevAcc != 5) begin
            testsFailed++;
            $display("FAIL rr_spacing: accept gap %0d, required 5", cycle - prevAcc);
          end
        end
        prevAcc = cycle;
        sbQ.push_back(exp_t'{port: port, err: 1'b0,
                             result: s[port] ? ({1'b0, a[port]} - {1'b0, b[port]})
                                             : ({1'b0, a[port]} + {1'b0, b[port]})});
        lastGrantTb = port;
        jobs[port]++;
        expPort = !port;
        @(posedge clk);
        #1;
        a[port] = randOp(); b[port] = randOp(); s[port] = 1'($urandom_range(0, 1));
        drivePort(port, jobs[port] < 4, a[port], b[port], s[port]);
      end
      @(negedge clk);
    end
    drivePort(0, 1'b0, '0, '0, 1'b0);
    drivePort(1, 1'b0, '0, '0, 1'b0);
    testsRun++;
    if (jobs[0] != 4 || jobs[1] != 4) begin
      testsFailed++;
      $display("FAIL rr_count: jobs0=%0d jobs1=%0d, required 4 4", jobs[0], jobs[1]);
    end
    for (int g = 0; g < 20 && sbQ.size() != 0; g++) @(negedge clk);
  endtask

  task automatic test_max_operands();
    int acc;
    int starts = 0;
    bit unstable = 1'b0;
    logic [W-1:0] ones = '1;
    logic [W:0] e = '1;
    e[0] = 1'b0;
    issueJob(0, ones, ones, 1'b0, e, 1'b0, acc);
    drivePort(0, 1'b0, '0, '0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      if (bus.add_start === 1'b1) starts++;
      if (bus.add_in_a !== ones || bus.add_in_b !== ones || bus.add_subtract !== 1'b0) unstable = 1'b1;
    end
    testsRun++;
    if (starts != 1 || unstable) begin
      testsFailed++;
      $display("FAIL max_operands_hold: starts=%0d unstable=%0b, required 1 0", starts, unstable);
    end
    @(negedge clk);
    testsRun++;
    if (bus.resp0_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL max_latency: resp0_valid=%b at cycle 4, required 1", bus.resp0_valid);
    end
  endtask

  task automatic test_done_outside_wait();
    int acc;
    bit spurious = 1'b0;
    @(negedge clk);
    forceResult = '1;
    forceDone   = 1'b1;
    @(negedge clk);
    forceDone   = 1'b0;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0 || bus.add_start !== 1'b0) spurious = 1'b1;
    end
    testsRun++;
    if (spurious) begin
      testsFailed++;
      $display("FAIL idle_done: arbiter reacted to add_done in IDLE, required no activity");
    end
    issueJob(0, W'(32'h1234), W'(1), 1'b0, (W+1)'(32'h1235), 1'b0, acc);
    drivePort(0, 1'b0, '0, '0, 1'b0);
    waitResp(0, acc, 4, "after_idle_done");
  endtask

  task automatic test_slow_done();
    int acc;
    stubDelay = 10;
    issueJob(1, W'(100), W'(1), 1'b1, (W+1)'(99), 1'b0, acc);
    drivePort(1, 1'b0, '0, '0, 1'b0);
    waitResp(1, acc, 13, "slow_done");
    stubDelay = 1;
  endtask

  task automatic test_reset_mid_job();
    int acc;
    issueJob(0, W'(7), W'(9), 1'b0, (W+1)'(16), 1'b0, acc);
    drivePort(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    sbQ.delete();
    #1;
    testsRun++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_err,
         bus.add_start, bus.add_subtract} !== 7'b0 || bus.resp_result !== '0 ||
        bus.add_in_a !== '0 || bus.add_in_b !== '0) begin
      testsFailed++;
      $display("FAIL midjob_reset_outputs: add_in_a low=%h resp_result low=%h, required all 0",
               bus.add_in_a[63:0], bus.resp_result[63:0]);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    lastGrantTb = 1'b1;
    repeat (5) @(negedge clk);
    issueJob(1, W'(11), W'(4), 1'b1, (W+1)'(7), 1'b0, acc);
    drivePort(1, 1'b0, '0, '0, 1'b0);
    waitResp(1, acc, 4, "after_reset");
  endtask

`ifdef MPADD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    stubEnable = 1'b0;
    issueJob(0, W'(1), W'(2), 1'b0, '0, 1'b1, acc);
    drivePort(0, 1'b0, '0, '0, 1'b0);
    waitResp(0, acc, TO + 2, "timeout");
    stubEnable = 1'b1;
  endtask
`endif

  initial begin
    resetn = 1'b0;
    drivePort(0, 1'b0, '0, '0, 1'b0);
    drivePort(1, 1'b0, '0, '0, 1'b0);
    test_reset();
    test_port0_add();
    test_port1_sub();
    test_round_robin();
    test_max_operands();
    test_done_outside_wait();
    test_slow_done();
    test_reset_mid_job();
`ifdef MPADD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    for (int g = 0; g < 100 && sbQ.size() != 0; g++) @(negedge clk);
    testsRun++;
    if (sbQ.size() != 0) begin
      testsFailed++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
